// File: rtl/cg_bank_controller.sv
// -----------------------------------------------------------------------------
// cg_bank_controller
//
// Clock-gating controller and round-robin write arbiter for a bank of NGRP
// register groups. Each group sits behind its own ICG cell. A group's clock is
// woken when its requester asks to write (or when force_on is set). The group
// is written only once its clock has been running for two cycles. After a
// programmable idle hold-off with no activity, the clock is gated again.
//
// Ports
//   clk       in   system clock, all state updates on the rising edge
//   rst_n     in   asynchronous active-low reset
//   req       in   per-requester write request (level, held until gnt seen)
//   req_data  in   write data, slice i (DW bits) belongs to requester i
//   force_on  in   global override that holds every group clock open
//   gnt       out  one-hot grant pulse (registered)
//   wr_en     out  one-hot write enable to the groups (registered, == gnt)
//   d_out     out  data of the granted requester, aligned with wr_en
//   gclk_en   out  per-group ICG enable (registered)
//   busy      out  OR of gclk_en
//
// Per-group FSM
//   state  | meaning
//   GATED  | clock stopped, waiting for a request or force_on
//   WAKE   | clock enabled, first cycle, group not yet writable
//   ACTIVE | clock running, group eligible for grants, idle timer runs
// -----------------------------------------------------------------------------
module cg_bank_controller #(
  parameter int NGRP     = 5,
  parameter int DW       = 1,
  parameter int IDLE_CYC = 4,
  parameter int CW       = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NGRP-1:0]    req,
  input  logic [NGRP*DW-1:0] req_data,
  input  logic               force_on,
  output logic [NGRP-1:0]    gnt,
  output logic [NGRP-1:0]    wr_en,
  output logic [DW-1:0]      d_out,
  output logic [NGRP-1:0]    gclk_en,
  output logic               busy
);

  localparam int PW = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYC);

  typedef enum logic [1:0] {
    GATED  = 2'd0,
    WAKE   = 2'd1,
    ACTIVE = 2'd2
  } grp_state_e;

  grp_state_e          state_q [NGRP];
  grp_state_e          state_d [NGRP];
  logic [CW-1:0]       cnt_q   [NGRP];
  logic [CW-1:0]       cnt_d   [NGRP];
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       ptr_d;
  logic [NGRP-1:0]     eligible;
  logic [NGRP-1:0]     grant_hit;
  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [NGRP-1:0]     gnt_d;
  logic [NGRP-1:0]     gclk_en_d;
  logic [DW-1:0]       d_out_d;

  // Index of the requester 'off' positions after 'base', wrapping modulo NGRP.
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base,
                                             input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NGRP) sum = sum - NGRP;
    return PW'(sum);
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration: only groups whose clock has already been running for a cycle
  // (ACTIVE) may be written. Search starts one past the last winner.
  // ---------------------------------------------------------------------------
  always_comb begin : arbiter
    eligible  = '0;
    grant_hit = '0;
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = 0; i < NGRP; i++) begin
      eligible[i] = req[i] && (state_q[i] == ACTIVE);
    end
    for (int k = 1; k <= NGRP; k++) begin
      if (!win_found && eligible[rr_index(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_index(ptr_q, k);
      end
    end
    for (int i = 0; i < NGRP; i++) begin
      grant_hit[i] = win_found && (win_idx == PW'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for every group FSM, its idle down-counter and the
  // round-robin pointer.
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    for (int i = 0; i < NGRP; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];

      case (state_q[i])
        GATED: begin
          if (req[i] || force_on) state_d[i] = WAKE;
        end
        WAKE: begin
          state_d[i] = ACTIVE;
        end
        ACTIVE: begin
          // A request landing on the expiry edge keeps the clock running.
          if ((cnt_q[i] == '0) && !req[i] && !force_on && !grant_hit[i]) begin
            state_d[i] = GATED;
          end
        end
        default: begin
          state_d[i] = GATED;
        end
      endcase

      // Leaving WAKE is the entry into ACTIVE, so the hold-off restarts there.
      if (force_on || req[i] || grant_hit[i] || (state_q[i] == WAKE)) begin
        cnt_d[i] = IDLE_LOAD;
      end else if ((state_q[i] == ACTIVE) && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end

    ptr_d = win_found ? win_idx : ptr_q;
  end

  // ---------------------------------------------------------------------------
  // Output decode, computed from the next state so every output is a flop.
  // d_out keeps the last written value between grants.
  // ---------------------------------------------------------------------------
  always_comb begin : output_decode
    gnt_d     = grant_hit;
    gclk_en_d = '0;
    for (int i = 0; i < NGRP; i++) begin
      gclk_en_d[i] = (state_d[i] != GATED);
    end
    d_out_d = d_out;
    if (win_found) begin
      d_out_d = req_data[int'(win_idx)*DW +: DW];
    end
  end

  // ---------------------------------------------------------------------------
  // State register. Reset is immediate so a write in flight is dropped in the
  // same cycle the reset is asserted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      for (int i = 0; i < NGRP; i++) begin
        state_q[i] <= GATED;
        cnt_q[i]   <= '0;
      end
      ptr_q   <= PW'(NGRP - 1);
      gnt     <= '0;
      wr_en   <= '0;
      d_out   <= '0;
      gclk_en <= '0;
    end else begin
      for (int i = 0; i < NGRP; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      wr_en   <= gnt_d;
      d_out   <= d_out_d;
      gclk_en <= gclk_en_d;
    end
  end

  assign busy = |gclk_en;

endmodule

// File: tb/tb_cg_bank_controller.sv
// -----------------------------------------------------------------------------
// tb_cg_bank_controller
//
// Table of cycle vectors from reset, hand-written corner sequences, then a
// randomized run compared against a timestamp-based reference model.
// -----------------------------------------------------------------------------
module tb_cg_bank_controller;

  localparam int NGRP     = 5;
  localparam int DW       = 1;
  localparam int IDLE_CYC = 4;
  localparam int CW       = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NGRP-1:0]    req;
  logic [NGRP*DW-1:0] req_data;
  logic               force_on;
  logic [NGRP-1:0]    gnt;
  logic [NGRP-1:0]    wr_en;
  logic [DW-1:0]      d_out;
  logic [NGRP-1:0]    gclk_en;
  logic               busy;

  cg_bank_controller #(
    .NGRP(NGRP), .DW(DW), .IDLE_CYC(IDLE_CYC), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .force_on(force_on), .gnt(gnt), .wr_en(wr_en), .d_out(d_out),
    .gclk_en(gclk_en), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit use_model = 1'b0;

  // Reference model: a group is awake from the edge that woke it; it may be
  // written from the second edge after that; it gates on the first edge more
  // than IDLE_CYC edges after its last keep-alive event.
  int              edge_n;
  int              wake_edge [NGRP];
  int              last_evt  [NGRP];
  int              rr_last;
  logic [NGRP-1:0] m_gnt;
  logic [NGRP-1:0] m_gclk;
  logic [DW-1:0]   m_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    edge_n  = 0;
    rr_last = NGRP - 1;
    m_gnt   = '0;
    m_gclk  = '0;
    m_dout  = '0;
    for (int i = 0; i < NGRP; i++) begin
      wake_edge[i] = -1;
      last_evt[i]  = 0;
    end
  endtask

  task automatic model_edge();
    int w;
    logic [NGRP-1:0] elig;
    edge_n++;
    w = -1;
    for (int i = 0; i < NGRP; i++)
      elig[i] = req[i] && (wake_edge[i] >= 0) && ((edge_n - wake_edge[i]) >= 2);
    for (int k = 1; k <= NGRP; k++) begin
      int j;
      j = (rr_last + k) % NGRP;
      if (w < 0 && elig[j]) w = j;
    end
    m_gnt = '0;
    if (w >= 0) begin
      m_gnt[w] = 1'b1;
      m_dout   = req_data[w*DW +: DW];
      rr_last  = w;
    end
    for (int i = 0; i < NGRP; i++) begin
      if (wake_edge[i] < 0) begin
        if (req[i] || force_on) begin
          wake_edge[i] = edge_n;
          last_evt[i]  = edge_n;
        end
      end else if ((edge_n - wake_edge[i]) == 1) begin
        last_evt[i] = edge_n;
      end else if (req[i] || force_on || (w == i)) begin
        last_evt[i] = edge_n;
      end else if ((edge_n - last_evt[i]) > IDLE_CYC) begin
        wake_edge[i] = -1;
      end
      m_gclk[i] = (wake_edge[i] >= 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (use_model) begin
      check("m_gnt", 32'(gnt), 32'(m_gnt));
      check("m_wr_en", 32'(wr_en), 32'(m_gnt));
      check("m_gclk_en", 32'(gclk_en), 32'(m_gclk));
      check("m_busy", 32'(busy), 32'(|m_gclk));
      if (m_gnt != '0) check("m_d_out", 32'(d_out), 32'(m_dout));
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    force_on = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NGRP-1:0]    req;
    logic [NGRP*DW-1:0] data;
    logic               force_on;
    logic [NGRP-1:0]    gnt;
    logic [NGRP-1:0]    gclk;
    logic               busy;
    logic [DW-1:0]      dout;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // cold wake of group 2, then parallel wake of groups 3 and 0
    tbl[0]  = '{5'b00100, 5'b00100, 1'b0, 5'b00000, 5'b00100, 1'b1, 1'b0};
    tbl[1]  = '{5'b00100, 5'b00100, 1'b0, 5'b00000, 5'b00100, 1'b1, 1'b0};
    tbl[2]  = '{5'b00100, 5'b00100, 1'b0, 5'b00100, 5'b00100, 1'b1, 1'b1};
    tbl[3]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00100, 1'b1, 1'b0};
    tbl[4]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00100, 1'b1, 1'b0};
    tbl[5]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00100, 1'b1, 1'b0};
    tbl[6]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00100, 1'b1, 1'b0};
    tbl[7]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[8]  = '{5'b01001, 5'b01000, 1'b0, 5'b00000, 5'b01001, 1'b1, 1'b0};
    tbl[9]  = '{5'b01001, 5'b01000, 1'b0, 5'b00000, 5'b01001, 1'b1, 1'b0};
    tbl[10] = '{5'b01001, 5'b01000, 1'b0, 5'b01000, 5'b01001, 1'b1, 1'b1};
    tbl[11] = '{5'b00001, 5'b00000, 1'b0, 5'b00001, 5'b01001, 1'b1, 1'b0};
    tbl[12] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b01001, 1'b1, 1'b0};
    tbl[13] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b01001, 1'b1, 1'b0};
    tbl[14] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b01001, 1'b1, 1'b0};
    tbl[15] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00001, 1'b1, 1'b0};
    tbl[16] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0};

    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    force_on = 1'b0;
    #1;
    check("rst_gclk_en", 32'(gclk_en), 32'(0));
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_wr_en", 32'(wr_en), 32'(0));
    check("rst_d_out", 32'(d_out), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));

    // idle after reset
    do_reset();
    for (int n = 0; n < 10; n++) begin
      step();
      check("idle_gclk_en", 32'(gclk_en), 32'(0));
      check("idle_gnt", 32'(gnt), 32'(0));
      check("idle_busy", 32'(busy), 32'(0));
    end

    // vector table
    do_reset();
    for (int v = 0; v < 17; v++) begin
      req      = tbl[v].req;
      req_data = tbl[v].data;
      force_on = tbl[v].force_on;
      step();
      check($sformatf("tbl%0d_gnt", v), 32'(gnt), 32'(tbl[v].gnt));
      check($sformatf("tbl%0d_wr_en", v), 32'(wr_en), 32'(tbl[v].gnt));
      check($sformatf("tbl%0d_gclk_en", v), 32'(gclk_en), 32'(tbl[v].gclk));
      check($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].busy));
      if (tbl[v].gnt != '0) check($sformatf("tbl%0d_d_out", v), 32'(d_out), 32'(tbl[v].dout));
    end

    // round-robin with everyone requesting continuously
    do_reset();
    req      = '1;
    req_data = 5'b10110;
    step();
    check("rr_wake_gnt", 32'(gnt), 32'(0));
    step();
    check("rr_act_gnt", 32'(gnt), 32'(0));
    for (int g = 0; g < 6; g++) begin
      int e;
      e = g % NGRP;
      step();
      check($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(1 << e));
      check($sformatf("rr%0d_d_out", g), 32'(d_out), 32'(req_data[e]));
      check($sformatf("rr%0d_gclk_en", g), 32'(gclk_en), 32'(5'b11111));
    end

    // request arriving on the expiry edge of group 1
    do_reset();
    req      = 5'b00010;
    req_data = 5'b00010;
    repeat (3) step();
    check("exp_first_gnt", 32'(gnt), 32'(5'b00010));
    req = '0;
    for (int n = 0; n < 4; n++) begin
      step();
      check($sformatf("exp_hold%0d_gclk_en", n), 32'(gclk_en), 32'(5'b00010));
      check($sformatf("exp_hold%0d_gnt", n), 32'(gnt), 32'(0));
    end
    req = 5'b00010;
    step();
    check("exp_rereq_gclk_en", 32'(gclk_en), 32'(5'b00010));
    check("exp_rereq_gnt", 32'(gnt), 32'(5'b00010));

    // force_on holds all gates, then a normal countdown on release
    do_reset();
    force_on = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      check($sformatf("force%0d_gclk_en", n), 32'(gclk_en), 32'(5'b11111));
    end
    force_on = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      step();
      check($sformatf("unforce%0d_gclk_en", n), 32'(gclk_en), 32'(5'b11111));
    end
    step();
    check("unforce5_gclk_en", 32'(gclk_en), 32'(0));
    check("unforce5_busy", 32'(busy), 32'(0));

    // asynchronous reset while group 3 is being written
    do_reset();
    req      = 5'b01000;
    req_data = 5'b01000;
    repeat (3) step();
    check("ar_pre_wr_en", 32'(wr_en), 32'(5'b01000));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_wr_en", 32'(wr_en), 32'(0));
    check("ar_gnt", 32'(gnt), 32'(0));
    check("ar_gclk_en", 32'(gclk_en), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_wake_gclk_en", 32'(gclk_en), 32'(5'b01000));
    check("ar_wake_gnt", 32'(gnt), 32'(0));
    step();
    check("ar_act_gnt", 32'(gnt), 32'(0));
    step();
    check("ar_regrant_gnt", 32'(gnt), 32'(5'b01000));
    check("ar_regrant_d_out", 32'(d_out), 32'(1));

    // randomized traffic against the reference model
    do_reset();
    use_model = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NGRP; i++) begin
        if (req[i]) begin
          if (gnt[i] && ($urandom_range(3) != 0)) req[i] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          req[i] = 1'b1;
        end
      end
      req_data = (NGRP*DW)'($urandom);
      if ($urandom_range(99) == 0) force_on = ~force_on;
      step();
    end
    use_model = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cg_bank_controller.md
Name: cg_bank_controller

Overview:
- Clock-gating controller and write arbiter for a bank of NGRP independently gated register groups.
- Each group is an enabled-flop register slice fed through an ICG cell.
- Arbitrates write requests from NGRP requesters round-robin, one write per cycle.
- Wakes each group's gated clock before it is written, and gates it off again after a programmable idle hold-off.

Parameters:
NGRP, 5, number of register groups / requesters.
DW, 1, data width per group write.
IDLE_CYC, 4, idle cycles after last request/grant before a group's clock is gated (legal range 1..2^CW-1).
CW, 3, width of per-group idle counter.

Ports:
CLK  input  1  system clock; all state on rising edge.
RST_N  input  1  asynchronous, active-low reset.
REQ  input  NGRP  per-requester write request, level, held until GNT seen.
REQ_DATA  input  NGRP*DW  write data; slice i belongs to requester i.
FORCE_ON  input  1  global override, holds every gate open.
GNT  output  NGRP  one-hot grant pulse, registered.
WR_EN  output  NGRP  one-hot write enable to group i, registered, equal to GNT.
D_OUT  output  DW  data of granted requester, registered, aligned with WR_EN.
GCLK_EN  output  NGRP  enable to each group's ICG, registered.
BUSY  output  1  OR of GCLK_EN.

Behaviour:
- Reset (RST_N low, async, immediate):
  - All groups return to GATED.
  - GNT=0, WR_EN=0, D_OUT=0, GCLK_EN=0, BUSY=0.
  - Idle counters are set to 0; RR pointer is set to NGRP-1, so group 0 has first priority.
  - Reset asserted mid-write drops WR_EN in the same cycle; no partial state survives.
- Per-group FSM, states GATED, WAKE, ACTIVE:
  - GATED -> WAKE when REQ[i]=1 or FORCE_ON=1 at an edge.
  - WAKE -> ACTIVE unconditionally at the next edge.
  - ACTIVE -> GATED when the idle counter is 0, REQ[i]=0, FORCE_ON=0 and group i is not being granted.
  - GCLK_EN[i] = (state != GATED), registered.
- Idle counter, per group:
  - Loaded to IDLE_CYC on entry to ACTIVE, on any edge with REQ[i]=1, and on grant of i.
  - Otherwise decrements by 1 in ACTIVE; saturates at 0.
  - FORCE_ON holds the counter at IDLE_CYC.
- Arbitration:
  - Eligible set = REQ[i]=1 and state ACTIVE at the edge.
  - Round-robin search begins at pointer+1 and wraps modulo NGRP.
  - Winner w: GNT[w]=WR_EN[w]=1 for exactly one cycle, and D_OUT=REQ_DATA slice w.
  - Pointer updates to w. With no eligible requester the pointer holds and GNT=0.
- Latency:
  - From GATED: REQ rises before edge k; WAKE at k; ACTIVE at k+1; GNT/WR_EN asserted after edge k+2. The group clock therefore runs 2 cycles before its first write.
  - Group already ACTIVE: GNT is asserted after the first edge that samples REQ.
- Handshake:
  - Requester drops REQ in the cycle GNT is high.
  - REQ still high at the next edge counts as a new request and may be re-granted, subject to round-robin.
- Simultaneous events:
  - A request arriving on the same edge the counter would expire keeps the group ACTIVE.
  - Multiple groups may wake in parallel; only one is granted per cycle.
  - Dropping FORCE_ON starts a normal idle countdown from IDLE_CYC.
- Fairness: with all NGRP requesting continuously, each requester is granted once every NGRP cycles.

Test Plan:
- Reset: hold RST_N=0, then release with REQ=0 -> GCLK_EN=00000, GNT=00000, BUSY=0 for 10 cycles.
- Cold wake: REQ=00100 with data 1 at edge 0 -> GCLK_EN[2]=1 after edge 0; GNT=00100, WR_EN=00100, D_OUT=1 after edge 2. REQ dropped -> GCLK_EN[2] falls after the 4 further idle edges (IDLE_CYC=4).
- Round-robin: REQ=11111 held with all groups ACTIVE -> grant order 0,1,2,3,4,0 and each GNT is one-hot.
- Request at expiry: re-raise REQ[1] on the edge its counter reaches 0 -> GCLK_EN[1] stays 1 with no WAKE cycle; grant follows on the next edge.
- FORCE_ON: FORCE_ON=1 for 20 cycles with REQ=0 -> GCLK_EN=11111 throughout. Drop FORCE_ON -> all gates close 5 edges later (4 countdown edges plus the GATED transition).
- Async reset while WR_EN=01000: assert RST_N=0 between edges -> WR_EN, GNT and GCLK_EN go to 0 immediately. After release, group 3 needs the full wake sequence again.
